// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS symbol constants, symbol type and width helpers
package tmds_pkg;
   localparam int TMDS_WIDTH = 10;

   typedef logic [TMDS_WIDTH-1:0] tmds_sym_t;

   // control-period symbols, named by {C1,C0}
   localparam tmds_sym_t TMDS_CTRL_00 = 10'b1101010100;
   localparam tmds_sym_t TMDS_CTRL_01 = 10'b0010101011;
   localparam tmds_sym_t TMDS_CTRL_10 = 10'b0101010100;
   localparam tmds_sym_t TMDS_CTRL_11 = 10'b1010101011;

   // index width for something with n distinct values, never below one bit
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int TMDS_BIT_IDX_W = idx_w(TMDS_WIDTH);
   localparam int TMDS_COUNT_W   = $clog2(TMDS_WIDTH + 1);
endpackage

// File: rtl/tmds_sym_fifo.sv
// rtl/tmds_sym_fifo.sv - synchronous symbol FIFO with registered occupancy, no fall-through
module tmds_sym_fifo
   import tmds_pkg::*;
#(
   parameter int DATA_W = 30,
   parameter int DEPTH  = 4,
   localparam int PTR_W = idx_w(DEPTH),
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;

   // full/empty come from the registered level, so a same-cycle pop never frees a slot
   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // pointer and occupancy bookkeeping; reset discards all contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/tmds_soft_serializer.sv
// rtl/tmds_soft_serializer.sv - multi-lane soft serializer; SERIALIZER_CLOCK_LANE_EN adds the out_clk lane
module tmds_soft_serializer
   import tmds_pkg::*;
#(
   parameter int              CHANNELS       = 3,
   parameter int              WIDTH          = TMDS_WIDTH,
   parameter int              BITS_PER_CYCLE = 2,
   parameter int              LSB_FIRST      = 1,
   parameter int              FIFO_DEPTH     = 4,
   parameter logic [WIDTH-1:0] IDLE_WORD     = TMDS_CTRL_00
) (
   input  logic                                   clk_pixel_x5,
   input  logic                                   reset,
   input  logic                                   enable,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [WIDTH-1:0]                       in_data [CHANNELS],
   output logic [CHANNELS-1:0][BITS_PER_CYCLE-1:0] out_bits,
   output logic                                   word_strobe,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_level,
   output logic                                   underrun,
   input  logic                                   clear_underrun
`ifdef SERIALIZER_CLOCK_LANE_EN
   ,
   output logic [BITS_PER_CYCLE-1:0]              out_clk
`endif
);
   localparam int                CYCLES    = WIDTH / BITS_PER_CYCLE;
   localparam int                SLOT_W    = idx_w(CYCLES);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CYCLES - 1);

   logic [SLOT_W-1:0]         slot;
   logic                      load;
   logic                      take;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [CHANNELS*WIDTH-1:0] wr_data;
   logic [CHANNELS*WIDTH-1:0] head;
   logic [WIDTH-1:0]          shreg [CHANNELS];

   // the shifter always emits bit 0 first, so MSB-first symbols are mirrored on entry
   function automatic logic [WIDTH-1:0] orient(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] r;
      r = s;
      if (LSB_FIRST == 0) begin
         for (int i = 0; i < WIDTH; i++) r[i] = s[WIDTH-1-i];
      end
      return r;
   endfunction

   assign load     = (slot == LAST_SLOT);
   assign take     = load && enable && !fifo_empty;
   assign in_ready = !fifo_full;

   // flatten the per-lane symbols into one FIFO entry, lane 0 in the low bits
   always_comb begin
      wr_data = '0;
      for (int c = 0; c < CHANNELS; c++) wr_data[c*WIDTH +: WIDTH] = in_data[c];
   end

   tmds_sym_fifo #(
      .DATA_W (CHANNELS * WIDTH),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_pixel_x5),
      .rst     (reset),
      .wr_en   (in_valid),
      .wr_data (wr_data),
      .rd_en   (take),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // slot counter, symbol-start strobe and sticky underrun flag (a new underrun beats a clear)
   always_ff @(posedge clk_pixel_x5 or posedge reset) begin
      if (reset) begin
         slot        <= LAST_SLOT;
         word_strobe <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         slot        <= load ? '0 : slot + 1'b1;
         word_strobe <= load;
         if (load && enable && fifo_empty) underrun <= 1'b1;
         else if (clear_underrun)          underrun <= 1'b0;
      end
   end

   // per-lane shift registers: load a symbol (or idle) at the boundary, otherwise shift out
   always_ff @(posedge clk_pixel_x5 or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) shreg[c] <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (load) shreg[c] <= orient(take ? head[c*WIDTH +: WIDTH] : IDLE_WORD);
            else      shreg[c] <= shreg[c] >> BITS_PER_CYCLE;
         end
      end
   end

   // outputs are the low end of each shift register, so nothing combinational reaches them
   always_comb begin
      out_bits = '0;
      for (int c = 0; c < CHANNELS; c++) out_bits[c] = shreg[c][BITS_PER_CYCLE-1:0];
   end

`ifdef SERIALIZER_CLOCK_LANE_EN
   // clock pattern in time order: WIDTH/2 ones in the earliest bits, then zeros
   localparam logic [WIDTH-1:0] CLK_PATTERN = {WIDTH{1'b1}} >> (WIDTH - WIDTH/2);

   logic [WIDTH-1:0] clk_sr;

   // clock lane restarts at every symbol boundary so it stays slot-aligned with the data
   always_ff @(posedge clk_pixel_x5 or posedge reset) begin
      if (reset)     clk_sr <= '0;
      else if (load) clk_sr <= CLK_PATTERN;
      else           clk_sr <= clk_sr >> BITS_PER_CYCLE;
   end

   assign out_clk = clk_sr[BITS_PER_CYCLE-1:0];
`endif
endmodule

// File: tb/tb_tmds_soft_serializer.sv
// tb/tb_tmds_soft_serializer.sv - self-checking bench for tmds_soft_serializer
module tb_tmds_soft_serializer;
   localparam int CH    = 3;
   localparam int W     = 10;
   localparam int B     = 2;
   localparam int DEPTH = 4;
   localparam int CYC   = W / B;
   localparam logic [W-1:0] IDLE = 10'b1101010100;

   typedef logic [CH-1:0][W-1:0] set_t;
   typedef logic [CH-1:0][B-1:0] bits_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic in_valid = 1'b0;
   logic clear_underrun = 1'b0;
   logic [W-1:0] in_data [CH];
   bits_t out_bits, out_bits_m;
   logic word_strobe, word_strobe_m, in_ready, in_ready_m, underrun, underrun_m;
   logic [2:0] fifo_level, fifo_level_m;
`ifdef SERIALIZER_CLOCK_LANE_EN
   logic [B-1:0] out_clk, out_clk_m;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [1:0] idle_exp [CYC] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};

   always #5 clk = ~clk;

   tmds_soft_serializer dut (
      .clk_pixel_x5 (clk), .reset (reset), .enable (enable), .in_valid (in_valid),
      .in_ready (in_ready), .in_data (in_data), .out_bits (out_bits),
      .word_strobe (word_strobe), .fifo_level (fifo_level), .underrun (underrun),
      .clear_underrun (clear_underrun)
`ifdef SERIALIZER_CLOCK_LANE_EN
      , .out_clk (out_clk)
`endif
   );

   tmds_soft_serializer #(.LSB_FIRST (0)) dut_msb (
      .clk_pixel_x5 (clk), .reset (reset), .enable (enable), .in_valid (in_valid),
      .in_ready (in_ready_m), .in_data (in_data), .out_bits (out_bits_m),
      .word_strobe (word_strobe_m), .fifo_level (fifo_level_m), .underrun (underrun_m),
      .clear_underrun (clear_underrun)
`ifdef SERIALIZER_CLOCK_LANE_EN
      , .out_clk (out_clk_m)
`endif
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // behavioural model: a queue of symbol sets, an edge count since reset, the current word
   set_t q[$];
   set_t m_word = '0;
   int   m_edges = 0;
   bit   m_und = 1'b0;

   task automatic model_step();
      int   pre;
      set_t in_set;
      pre = q.size();
      for (int c = 0; c < CH; c++) in_set[c] = in_data[c];
      if (m_edges % CYC == 0) begin
         if (enable && pre > 0) m_word = q.pop_front();
         else for (int c = 0; c < CH; c++) m_word[c] = IDLE;
         if (enable && pre == 0) m_und = 1'b1;
         else if (clear_underrun) m_und = 1'b0;
      end else if (clear_underrun) begin
         m_und = 1'b0;
      end
      if (in_valid && pre < DEPTH) q.push_back(in_set);
      m_edges++;
   endtask

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         q.delete();
         m_edges = 0;
         m_und   = 1'b0;
         m_word  = '0;
      end else begin
         model_step();
      end
   end

   function automatic bits_t exp_bits(input bit lsb);
      bits_t r;
      int s, t;
      r = '0;
      if (m_edges == 0) return r;
      s = (m_edges - 1) % CYC;
      for (int c = 0; c < CH; c++)
         for (int j = 0; j < B; j++) begin
            t = s * B + j;
            r[c][j] = lsb ? m_word[c][t] : m_word[c][W-1-t];
         end
      return r;
   endfunction

   function automatic logic exp_strobe();
      return (m_edges > 0) && ((m_edges - 1) % CYC == 0);
   endfunction

   function automatic logic [B-1:0] exp_clk();
      logic [B-1:0] r;
      r = '0;
      if (m_edges == 0) return r;
      for (int j = 0; j < B; j++) r[j] = (((m_edges - 1) % CYC) * B + j) < (W / 2);
      return r;
   endfunction

   // every-cycle comparison of both instances against the model
   initial forever begin
      @(negedge clk);
      check("out_bits", out_bits, exp_bits(1'b1));
      check("out_bits_msb", out_bits_m, exp_bits(1'b0));
      check("word_strobe", word_strobe, exp_strobe());
      check("word_strobe_msb", word_strobe_m, exp_strobe());
      check("in_ready", in_ready, q.size() < DEPTH);
      check("in_ready_msb", in_ready_m, q.size() < DEPTH);
      check("fifo_level", fifo_level, q.size());
      check("fifo_level_msb", fifo_level_m, q.size());
      check("underrun", underrun, m_und);
      check("underrun_msb", underrun_m, m_und);
`ifdef SERIALIZER_CLOCK_LANE_EN
      check("out_clk", out_clk, exp_clk());
      check("out_clk_msb", out_clk_m, exp_clk());
`endif
   end

   task automatic wait_strobe();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!word_strobe && n < 4 * CYC);
      check("strobe_timeout", word_strobe, 1'b1);
   endtask

   function automatic logic [W-1:0] mk(input int i, input int c);
      return W'(i * 97 + c * 211 + 5);
   endfunction

   task automatic set_all(input logic [W-1:0] v);
      for (int c = 0; c < CH; c++) in_data[c] = v;
   endtask

   initial begin
      int n;
      set_all('0);
      repeat (3) @(negedge clk);
      check("rst_out_bits", out_bits, '0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_level", fifo_level, 0);
      check("rst_underrun", underrun, 1'b0);
      check("rst_strobe", word_strobe, 1'b0);
      reset = 1'b0;

      // idle symbol after reset, enable low
      for (int k = 0; k < CYC; k++) begin
         @(negedge clk);
         check("idle_slot", out_bits[0], idle_exp[k]);
         check("idle_strobe", word_strobe, k == 0);
         check("idle_underrun", underrun, 1'b0);
      end

      // one data set, then enable
      in_data[0] = 10'h3FF; in_data[1] = 10'h000; in_data[2] = 10'h155;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      enable = 1'b1;
      wait_strobe();
      for (int k = 0; k < CYC; k++) begin
         if (k > 0) @(negedge clk);
         check("data_ch0", out_bits[0], 2'b11);
         check("data_ch1", out_bits[1], 2'b00);
         check("data_ch2", out_bits[2], 2'b01);
         check("data_strobe", word_strobe, k == 0);
      end

      // underrun set, clear colliding with a new underrun, then a clean clear
      @(negedge clk);
      check("underrun_set", underrun, 1'b1);
      check("underrun_idle", out_bits[0], 2'b00);
      repeat (4) @(negedge clk);
      clear_underrun = 1'b1;
      @(negedge clk);
      check("underrun_clr_vs_set", underrun, 1'b1);
      @(negedge clk);
      clear_underrun = 1'b0;
      check("underrun_cleared", underrun, 1'b0);
      enable = 1'b0;

      // fill the FIFO with enable low; fifth set must be held
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < CH; c++) in_data[c] = mk(i, c);
         @(negedge clk);
      end
      for (int c = 0; c < CH; c++) in_data[c] = mk(4, c);
      check("full_ready", in_ready, 1'b0);
      check("full_level", fifo_level, 4);
      @(negedge clk);
      check("full_hold_level", fifo_level, 4);
      enable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 4 * CYC);
      check("ready_return", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check("level_refill", fifo_level, 4);
      repeat (6 * CYC) @(negedge clk);

      // MSB-first ordering of a single high bit
      enable = 1'b0;
      clear_underrun = 1'b1;
      @(negedge clk);
      clear_underrun = 1'b0;
      set_all(10'h200);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      enable = 1'b1;
      wait_strobe();
      for (int k = 0; k < CYC; k++) begin
         if (k > 0) @(negedge clk);
         check("msb_first_slot", out_bits_m[0], (k == 0) ? 2'b01 : 2'b00);
         check("lsb_first_slot", out_bits[0], (k == CYC - 1) ? 2'b10 : 2'b00);
      end

      // reset in slot 2 of a data symbol
      set_all(10'h3FF);
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_strobe();
      repeat (2) @(negedge clk);
      check("pre_reset_bits", out_bits[0], 2'b11);
      check("pre_reset_level", fifo_level, 1);
      #1 reset = 1'b1;
      #1;
      check("async_rst_bits", out_bits, '0);
      check("async_rst_level", fifo_level, 0);
      check("async_rst_strobe", word_strobe, 1'b0);
      check("async_rst_ready", in_ready, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < CYC; k++) begin
         @(negedge clk);
         check("post_rst_idle0", out_bits[0], idle_exp[k]);
         check("post_rst_idle2", out_bits[2], idle_exp[k]);
`ifdef SERIALIZER_CLOCK_LANE_EN
         if (k == 0) check("post_rst_clk", out_clk, 2'b11);
`endif
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tmds_soft_serializer.md
Name: tmds_soft_serializer

Overview:
- Parametrised, vendor-independent multi-lane serializer; replaces the per-board LVDS-macro wrapper with portable RTL.
- Accepts parallel symbols (e.g. TMDS 10-bit) via valid/ready into a small FIFO.
- Emits BITS_PER_CYCLE bits per lane per clock to downstream DDIO/output cells.
- Sits between the TMDS encoders and the board I/O; runs entirely in the serial-rate clock domain.

Parameters:
- CHANNELS, 3, number of data lanes.
- WIDTH, 10, symbol width in bits; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 2, bits per lane per clock (2 = DDR at 5x pixel clock; 1 = SDR).
- LSB_FIRST, 1, 1: bit 0 transmitted first; 0: bit WIDTH-1 first.
- FIFO_DEPTH, 4, symbol-FIFO depth in CHANNELS-wide entries; power of 2, >= 2.
- IDLE_WORD, 10'b1101010100, symbol sent on every lane when no data is taken (WIDTH bits).

Ports:
- clk_pixel_x5  in  1  serial-rate clock, the only clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = pop FIFO at symbol boundaries; 0 = send IDLE_WORD without popping.
- in_valid  in  1  symbol set valid.
- in_ready  out  1  FIFO not full.
- in_data  in  [WIDTH-1:0] x CHANNELS (unpacked, index = lane)  one symbol per lane.
- out_bits  out  [CHANNELS-1:0][BITS_PER_CYCLE-1:0]  per-lane bit group; bit 0 is earlier in time.
- word_strobe  out  1  high in the first slot of every symbol.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- underrun  out  1  sticky: FIFO empty at a load edge while enable=1.
- clear_underrun  in  1  clears underrun.

Behaviour:
- Clock and reset: single clock, asynchronous active-high reset, all state on clk_pixel_x5.
- Reset values: out_bits=0, word_strobe=0, in_ready=1, fifo_level=0, underrun=0, FIFO empty, slot counter = CYCLES-1 (CYCLES = WIDTH/BITS_PER_CYCLE), shift registers=0.
- FIFO write: on in_valid && in_ready.
- in_ready: = !full, from registered occupancy. A simultaneous pop does not allow a write while full.
- Load edge: the clock edge where slot == CYCLES-1. Slot counter -> 0.
  - Each lane shift register loads the FIFO head if enable=1 and FIFO non-empty; the entry is popped.
  - Otherwise each lane loads IDLE_WORD.
  - The first edge after reset is a load edge.
- Non-load edges: shift by BITS_PER_CYCLE toward the output end; slot++.
- Output ordering: out_bits is taken directly from the shift register (registered, no combinational path from inputs).
  - LSB_FIRST=1: slot k shows bits {kB+B-1 .. kB}.
  - LSB_FIRST=0: symbol is bit-reversed at load, then handled as for LSB_FIRST=1.
- Latency: no fall-through. A word written on the same edge as a load edge is not seen by that load. A word in the FIFO before load edge L appears in out_bits slot 0 in the cycle after L.
- word_strobe: registered; high exactly in the cycle out_bits shows slot 0.
- enable: sampled only at load edges. Changes mid-symbol never truncate a symbol.
- Underrun: set at a load edge with enable=1 and FIFO empty; IDLE_WORD is sent.
  - clear_underrun clears it.
  - Simultaneous clear and new underrun: stays set.
- fifo_level: updated the cycle after push/pop; simultaneous push and pop leave it unchanged.
- Reset mid-symbol: outputs go to reset values immediately and FIFO contents are discarded.

Optional Feature:
- Macro: SERIALIZER_CLOCK_LANE_EN.
- Defined: adds port out_clk [BITS_PER_CYCLE-1:0].
  - Emits the TMDS clock pattern, WIDTH/2 ones then WIDTH/2 zeros in time order.
  - Slot-aligned with out_bits, restarts at every load edge, reset value 0.
- Undefined: port and logic absent; the clock lane is generated externally.

Decomposition:
- Package tmds_pkg: TMDS_WIDTH=10, TMDS_CTRL_00..11 idle symbols, typedef tmds_sym_t (logic [9:0]), clog2-based width helper constants.
- Sub-module: tmds_sym_fifo (parametrised synchronous FIFO with level output), instantiated once with CHANNELS*WIDTH data width.

Test Plan (defaults unless stated):
- Reset with enable=0: out_bits=0, in_ready=1, level=0, underrun=0. Slots 0..4 per lane are then 2'b00,01,01,01,11 (IDLE_WORD LSB-first), with underrun staying 0.
- Push ch0=10'h3FF, ch1=10'h000, ch2=10'h155, then enable=1: after the next load edge ch0=2'b11, ch1=2'b00, ch2=2'b01 for 5 cycles. word_strobe high in the first of those cycles only.
- LSB_FIRST=0, push 10'b1000000000 on all lanes: slot 0 = 2'b01, slots 1..4 = 2'b00.
- enable=0, push 5 symbols back-to-back: in_ready drops after the 4th accept, level=4, 5th held until a pop at a load edge after enable=1.
- enable=1 with FIFO empty: underrun rises at the load edge and IDLE_WORD is sent. Assert clear_underrun on the next underrun edge: underrun stays 1. Clear on a non-underrun cycle: underrun goes to 0.
- Assert reset in slot 2 of a data symbol: out_bits=0 asynchronously, level=0. After release, the first symbol is IDLE_WORD (with the clock-lane macro, out_clk restarts at 2'b11).
